// File: rtl/regfile_pkg.sv
// Shared defaults for the ID-stage register file: widths, reset image and register indices.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned NREGS_DEF  = 1 << ADDR_W_DEF;
    localparam int unsigned R0_IDX     = 0;

    localparam logic [15:0] RESET_VAL [NREGS_DEF] = '{
        16'h0000, 16'h0F00, 16'h0050, 16'hFF0F,
        16'hF0FF, 16'h0040, 16'h0024, 16'h00FF,
        16'hAAAA, 16'h0000, 16'h0000, 16'h0000,
        16'hFFFF, 16'h0002, 16'h0000, 16'h0000
    };

    // Registers beyond the default table come out of reset as zero.
    function automatic logic [15:0] reset_word(input int unsigned idx);
        if (idx < NREGS_DEF) begin
            return RESET_VAL[idx[ADDR_W_DEF-1:0]];
        end
        return 16'h0000;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Operand-read, write-back, accumulator and issue signals between decode and the register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic              use1;
    logic              use2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              r0_we;
    logic [DATA_W-1:0] r0_wd;
    logic [DATA_W-1:0] r0_rd;
    logic              iss_valid;
    logic              iss_wr;
    logic [ADDR_W-1:0] iss_dst;
    logic              iss_ok;
    logic              stall;
    logic              stat_clr;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output ra1, ra2, use1, use2, we, wa, wd, r0_we, r0_wd,
               iss_valid, iss_wr, iss_dst, stat_clr,
        input  rd1, rd2, r0_rd, iss_ok, stall, stall_cnt
    );

    modport slave (
        input  ra1, ra2, use1, use2, we, wa, wd, r0_we, r0_wd,
               iss_valid, iss_wr, iss_dst, stat_clr,
        output rd1, rd2, r0_rd, iss_ok, stall, stall_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight destinations, raises stall on RAW/WAW hazards,
// and counts stalled cycles with saturation.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = CNT_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_ra1,
    input  logic [ADDR_W-1:0] i_ra2,
    input  logic              i_use1,
    input  logic              i_use2,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic              i_r0_we,
    input  logic              i_iss_valid,
    input  logic              i_iss_wr,
    input  logic [ADDR_W-1:0] i_iss_dst,
    input  logic              i_stat_clr,
    output logic              o_iss_ok_c,
    output logic              o_stall_c,
    output logic [CNT_W-1:0]  o_stall_cnt
);
    localparam int unsigned      NREGS   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(R0_IDX);
    localparam bit               L_BYP   = (BYPASS != 0);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [NREGS-1:0] w_clr;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_busy1;
    logic             w_busy2;
    logic             w_waw;
    logic             w_stall;
    logic             w_iss_ok;

    // Registers being retired by write-back this cycle.
    always_comb begin
        w_clr = '0;
        if (i_we) begin
            w_clr[i_wa] = 1'b1;
        end
        if (i_r0_we) begin
            w_clr[R0_ADDR] = 1'b1;
        end
    end

    // A clearing write only hides a RAW hazard when its data is forwarded; WAW always sees it.
    always_comb begin
        w_busy1    = r_busy[i_ra1] & ~(L_BYP & w_clr[i_ra1]);
        w_busy2    = r_busy[i_ra2] & ~(L_BYP & w_clr[i_ra2]);
        w_waw      = i_iss_wr & r_busy[i_iss_dst] & ~w_clr[i_iss_dst];
        w_stall    = i_iss_valid & ((i_use1 & w_busy1) | (i_use2 & w_busy2) | w_waw);
        w_iss_ok   = i_iss_valid & ~w_stall;
        w_busy_nxt = r_busy & ~w_clr;
        if (w_iss_ok && i_iss_wr) begin
            w_busy_nxt[i_iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (i_stat_clr) begin
                r_stall_cnt <= '0;
            end else if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_iss_ok_c  = w_iss_ok;
    assign o_stall_c   = w_stall;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/regfile_sb.sv
// ID-stage register file with R0 accumulator port, optional write-to-read bypass
// and a hazard scoreboard gating instruction issue.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = CNT_W_DEF
)(
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int unsigned       NREGS   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(R0_IDX);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_r0_rd;
    logic              w_iss_ok;
    logic              w_stall;
    logic [CNT_W-1:0]  w_stall_cnt;

    // Storage: accumulator write is applied last so it beats a write-back to R0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[ADDR_W'(i)] <= DATA_W'(reset_word(i));
            end
        end else begin
            if (bus.we) begin
                r_regs[bus.wa] <= bus.wd;
            end
            if (bus.r0_we) begin
                r_regs[R0_ADDR] <= bus.r0_wd;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic              r0_we,
        input logic [DATA_W-1:0] r0_wd
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if (BYPASS != 0) begin
            if (we && (wa == a)) begin
                v = wd;
            end
            if (r0_we && (a == R0_ADDR)) begin
                v = r0_wd;
            end
        end
        return v;
    endfunction

    always_comb begin
        w_rd1   = read_port(bus.ra1, r_regs[bus.ra1], bus.we, bus.wa, bus.wd, bus.r0_we, bus.r0_wd);
        w_rd2   = read_port(bus.ra2, r_regs[bus.ra2], bus.we, bus.wa, bus.wd, bus.r0_we, bus.r0_wd);
        w_r0_rd = read_port(R0_ADDR, r_regs[R0_ADDR], bus.we, bus.wa, bus.wd, bus.r0_we, bus.r0_wd);
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_ra1       (bus.ra1),
        .i_ra2       (bus.ra2),
        .i_use1      (bus.use1),
        .i_use2      (bus.use2),
        .i_we        (bus.we),
        .i_wa        (bus.wa),
        .i_r0_we     (bus.r0_we),
        .i_iss_valid (bus.iss_valid),
        .i_iss_wr    (bus.iss_wr),
        .i_iss_dst   (bus.iss_dst),
        .i_stat_clr  (bus.stat_clr),
        .o_iss_ok_c  (w_iss_ok),
        .o_stall_c   (w_stall),
        .o_stall_cnt (w_stall_cnt)
    );

    assign bus.rd1       = w_rd1;
    assign bus.rd2       = w_rd2;
    assign bus.r0_rd     = w_r0_rd;
    assign bus.iss_ok    = w_iss_ok;
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = w_stall_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass/16-bit counter and no-bypass/4-bit counter)
// share one stimulus stream; a monitor checks each against a reference model via queues.
module tb_regfile_sb;

    typedef struct {
        logic        rst_n;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        use1;
        logic        use2;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        r0_we;
        logic [15:0] r0_wd;
        logic        iss_valid;
        logic        iss_wr;
        logic [3:0]  iss_dst;
        logic        stat_clr;
    } stim_t;

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] r0;
        logic        stall;
        logic        ok;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   mon_cyc = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Reference state: register contents are common, busy/count depend on the configuration.
    logic [15:0] m_reg [16];
    bit          m_busy [2][16];
    int          m_cnt [2];
    const bit    m_byp [2]     = '{1'b1, 1'b0};
    const int    m_cnt_max [2] = '{65535, 15};
    const logic [15:0] RV [16] = '{
        16'h0000, 16'h0F00, 16'h0050, 16'hFF0F, 16'hF0FF, 16'h0040, 16'h0024, 16'h00FF,
        16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000
    };

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(16)) bus_a ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(4))  bus_b ();

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .CNT_W(16)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .CNT_W(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", name, mon_cyc, act, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i]     = RV[i];
            m_busy[0][i] = 1'b0;
            m_busy[1][i] = 1'b0;
        end
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    function automatic logic [15:0] m_read(input int c, input logic [3:0] a, input stim_t s);
        if (m_byp[c]) begin
            if (s.r0_we && a == 4'd0) return s.r0_wd;
            if (s.we && s.wa == a) return s.wd;
        end
        return m_reg[a];
    endfunction

    function automatic bit m_clr(input logic [3:0] a, input stim_t s);
        return (s.we && s.wa == a) || (s.r0_we && a == 4'd0);
    endfunction

    task automatic drive(input stim_t s);
        bus_a.ra1 = s.ra1;  bus_b.ra1 = s.ra1;
        bus_a.ra2 = s.ra2;  bus_b.ra2 = s.ra2;
        bus_a.use1 = s.use1; bus_b.use1 = s.use1;
        bus_a.use2 = s.use2; bus_b.use2 = s.use2;
        bus_a.we = s.we;    bus_b.we = s.we;
        bus_a.wa = s.wa;    bus_b.wa = s.wa;
        bus_a.wd = s.wd;    bus_b.wd = s.wd;
        bus_a.r0_we = s.r0_we; bus_b.r0_we = s.r0_we;
        bus_a.r0_wd = s.r0_wd; bus_b.r0_wd = s.r0_wd;
        bus_a.iss_valid = s.iss_valid; bus_b.iss_valid = s.iss_valid;
        bus_a.iss_wr = s.iss_wr;   bus_b.iss_wr = s.iss_wr;
        bus_a.iss_dst = s.iss_dst; bus_b.iss_dst = s.iss_dst;
        bus_a.stat_clr = s.stat_clr; bus_b.stat_clr = s.stat_clr;
        rst = s.rst_n;
    endtask

    // One cycle: apply inputs after the edge, queue expected outputs, advance the model.
    task automatic step(input stim_t s);
        exp_t e [2];
        bit   b1, b2, waw;
        @(posedge clk);
        #1;
        drive(s);
        if (!s.rst_n) model_reset();
        for (int c = 0; c < 2; c++) begin
            b1  = m_busy[c][s.ra1] && !(m_byp[c] && m_clr(s.ra1, s));
            b2  = m_busy[c][s.ra2] && !(m_byp[c] && m_clr(s.ra2, s));
            waw = s.iss_wr && m_busy[c][s.iss_dst] && !m_clr(s.iss_dst, s);
            e[c].rd1   = m_read(c, s.ra1, s);
            e[c].rd2   = m_read(c, s.ra2, s);
            e[c].r0    = m_read(c, 4'd0, s);
            e[c].stall = s.iss_valid && ((s.use1 && b1) || (s.use2 && b2) || waw);
            e[c].ok    = s.iss_valid && !e[c].stall;
            e[c].cnt   = m_cnt[c];
        end
        qa.push_back(e[0]);
        qb.push_back(e[1]);
        if (s.rst_n) begin
            for (int c = 0; c < 2; c++) begin
                if (s.stat_clr) m_cnt[c] = 0;
                else if (e[c].stall && m_cnt[c] < m_cnt_max[c]) m_cnt[c]++;
                for (int i = 0; i < 16; i++) begin
                    if (m_clr(4'(i), s)) m_busy[c][i] = 1'b0;
                end
                if (e[c].ok && s.iss_wr) m_busy[c][s.iss_dst] = 1'b1;
            end
            if (s.we) m_reg[s.wa] = s.wd;
            if (s.r0_we) m_reg[0] = s.r0_wd;
        end
    endtask

    // Monitor: the DUT presents operands and issue status every cycle; compare at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("A.rd1",   32'(bus_a.rd1),       32'(e.rd1));
                chk("A.rd2",   32'(bus_a.rd2),       32'(e.rd2));
                chk("A.r0_rd", 32'(bus_a.r0_rd),     32'(e.r0));
                chk("A.stall", 32'(bus_a.stall),     32'(e.stall));
                chk("A.iss_ok",32'(bus_a.iss_ok),    32'(e.ok));
                chk("A.cnt",   32'(bus_a.stall_cnt), 32'(e.cnt));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("B.rd1",   32'(bus_b.rd1),       32'(e.rd1));
                chk("B.rd2",   32'(bus_b.rd2),       32'(e.rd2));
                chk("B.r0_rd", 32'(bus_b.r0_rd),     32'(e.r0));
                chk("B.stall", 32'(bus_b.stall),     32'(e.stall));
                chk("B.iss_ok",32'(bus_b.iss_ok),    32'(e.ok));
                chk("B.cnt",   32'(bus_b.stall_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        drive(s);
        model_reset();
        step(s);
        step(s);

        // Reset image and issue with no hazard.
        s = idle(); s.ra1 = 4'd1; s.ra2 = 4'd8; s.iss_valid = 1'b1;
        step(s);

        // Same-cycle write-back forwarding.
        s = idle(); s.we = 1'b1; s.wa = 4'd3; s.wd = 16'h1234; s.ra1 = 4'd3;
        step(s);
        s = idle(); s.ra1 = 4'd3;
        step(s);

        // Accumulator write beats write-back to R0.
        s = idle(); s.we = 1'b1; s.wa = 4'd0; s.wd = 16'h1111;
        s.r0_we = 1'b1; s.r0_wd = 16'h2222; s.ra1 = 4'd0;
        step(s);
        s = idle(); s.ra1 = 4'd0;
        step(s);

        // RAW stall on an in-flight destination, released by write-back.
        s = idle(); s.stat_clr = 1'b1;
        step(s);
        s = idle(); s.iss_valid = 1'b1; s.iss_wr = 1'b1; s.iss_dst = 4'd5;
        step(s);
        s = idle(); s.iss_valid = 1'b1; s.ra1 = 4'd5; s.use1 = 1'b1;
        repeat (3) step(s);
        s.we = 1'b1; s.wa = 4'd5; s.wd = 16'h5555;
        step(s);
        s.we = 1'b0;
        step(s);

        // Set beats clear on the same register; a second producer then hits WAW.
        s = idle(); s.iss_valid = 1'b1; s.iss_wr = 1'b1; s.iss_dst = 4'd6;
        step(s);
        s.we = 1'b1; s.wa = 4'd6; s.wd = 16'h6666;
        step(s);
        s.we = 1'b0;
        step(s);
        step(s);
        s = idle(); s.we = 1'b1; s.wa = 4'd6; s.wd = 16'h6767;
        step(s);

        // Long stall saturates the narrow counter; clear, then reset mid-stall.
        s = idle(); s.iss_valid = 1'b1; s.iss_wr = 1'b1; s.iss_dst = 4'd7;
        step(s);
        s = idle(); s.iss_valid = 1'b1; s.ra2 = 4'd7; s.use2 = 1'b1;
        repeat (20) step(s);
        s.stat_clr = 1'b1;
        step(s);
        s.stat_clr = 1'b0;
        repeat (2) step(s);
        s.rst_n = 1'b0;
        step(s);
        s.rst_n = 1'b1;
        step(s);
        s = idle(); s.we = 1'b1; s.wa = 4'd7; s.wd = 16'hBEEF; s.ra1 = 4'd7;
        step(s);
        s = idle(); s.ra1 = 4'd7;
        step(s);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            s = idle();
            s.ra1       = 4'($urandom);
            s.ra2       = 4'($urandom);
            s.use1      = 1'($urandom);
            s.use2      = 1'($urandom);
            s.we        = ($urandom % 10) < 4;
            s.wa        = 4'($urandom);
            s.wd        = 16'($urandom);
            s.r0_we     = ($urandom % 10) < 2;
            s.r0_wd     = 16'($urandom);
            s.iss_valid = ($urandom % 10) < 7;
            s.iss_wr    = 1'($urandom);
            s.iss_dst   = 4'($urandom);
            s.stat_clr  = ($urandom % 40) == 0;
            if (($urandom % 150) == 0) begin
                s.rst_n = 1'b0;
                s.we    = 1'b0;
                s.r0_we = 1'b0;
            end
            step(s);
        end

        s = idle();
        step(s);
        repeat (3) @(posedge clk);
        chk("queue_a_drained", 32'(qa.size()), 32'd0);
        chk("queue_b_drained", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
